accel_spi_responder: RTL and testbench

Device-side SPI responder modelling the three-axis accelerometer that the on-chip SPI sequencer talks to. It decodes the command byte, serves the register map (WHO_AM_I, CTRL_REG1, TEMP_CFG_REG, CTRL_REG4, OUT_X/Y/Z) with auto-increment, and accepts register writes. It serves as the bench-side peer for co-simulation and as a loopback target on FPGA. Axis samples come from ports, so the bench or a pattern generator sets what the initiator reads back.

---
 rtl/accel_regs_pkg.sv | 33 +++
 rtl/spi_pin_sync.sv | 41 ++++
 rtl/accel_spi_responder.sv | 185 ++++++++++++++++++
 tb/tb_accel_spi_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/accel_regs_pkg.sv
// Register map, reset values, command-byte fields and FSM encoding for the accelerometer SPI target.
// Latency: n/a (constants and types only).
// Backpressure: n/a; shared with the SPI sequencer so both sides agree on the map.
package accel_regs_pkg;

  // Register addresses (6-bit address field of the command byte)
  localparam logic [5:0] ADDR_WHO_AM_I  = 6'h0F;
  localparam logic [5:0] ADDR_TEMP_CFG  = 6'h1F;
  localparam logic [5:0] ADDR_CTRL_REG1 = 6'h20;
  localparam logic [5:0] ADDR_CTRL_REG4 = 6'h23;
  localparam logic [5:0] ADDR_OUT_X_L   = 6'h28;
  localparam logic [5:0] ADDR_OUT_X_H   = 6'h29;
  localparam logic [5:0] ADDR_OUT_Y_L   = 6'h2A;
  localparam logic [5:0] ADDR_OUT_Y_H   = 6'h2B;
  localparam logic [5:0] ADDR_OUT_Z_L   = 6'h2C;
  localparam logic [5:0] ADDR_OUT_Z_H   = 6'h2D;

  // Reset values of the writable registers
  localparam logic [7:0] CTRL_REG1_RST = 8'h07;
  localparam logic [7:0] TEMP_CFG_RST  = 8'h00;
  localparam logic [7:0] CTRL_REG4_RST = 8'h00;

  // Command byte fields: bit7 = read, bit6 = auto-increment, bits 5:0 = address
  localparam int CMD_RW_BIT = 7;
  localparam int CMD_MS_BIT = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes one asynchronous pin into clk_in and emits registered rise/fall strobes.
// Latency: STAGES+1 clk_in cycles from a pin edge to its strobe.
// Backpressure: none; every edge produces a strobe (pin must toggle slower than clk_in/2).
// Ports: i_pin (async input), o_rise/o_fall (one-cycle strobes in clk_in domain).
module spi_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic i_pin,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_rise;
  logic              r_fall;

  // Synchronizer flops run through reset so they always hold the real pin level;
  // the edge history tracks them during reset so release never fakes an edge.
  always_ff @(posedge clk_in) begin
    r_sync <= {r_sync[STAGES-2:0], i_pin};
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_prev <= r_sync[STAGES-1];
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_prev <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[STAGES-1] & r_prev;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/accel_spi_responder.sv
// SPI mode-3 accelerometer target: command decode, register map with auto-increment, register writes.
// Latency: pin-to-MISO SYNC_STAGES+2 clk_in cycles; writes land 1 cycle after the 8th-rise strobe.
// Backpressure: none; the initiator paces everything, clk_in must be >= 8x SCLK.
// Ports: clk_in/rst; SPI pins sclk, cs_n, mosi, miso, miso_oe; acc_x/y/z sample inputs;
//        ctrl_reg1/temp_cfg/ctrl_reg4 register outputs; xfer_done end-of-transfer pulse.
module accel_spi_responder
  import accel_regs_pkg::*;
#(
  parameter logic [7:0] WHO_AM_I_VAL = 8'h33,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [15:0] acc_x,
  input  logic [15:0] acc_y,
  input  logic [15:0] acc_z,
  output logic [7:0]  ctrl_reg1,
  output logic [7:0]  temp_cfg,
  output logic [7:0]  ctrl_reg4,
  output logic        xfer_done
);

  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .i_pin  (sclk),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .i_pin  (cs_n),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  // MOSI gets the same depth as the strobes' synchronizer; it is stable for
  // half an SCLK period around the rise, so the one-cycle skew is harmless.
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  always_ff @(posedge clk_in) begin
    r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
  end
  logic w_mosi;
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  spi_state_t  r_state, w_state_nxt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_byte_cnt;
  logic [6:0]  r_rx;
  logic [7:0]  r_tx;
  logic        r_rw, r_ms, r_load_pend;
  logic [5:0]  r_addr;
  logic [47:0] r_shadow;
  logic [7:0]  r_ctrl_reg1, r_temp_cfg, r_ctrl_reg4;
  logic        r_miso, r_miso_oe, r_xfer_done;

  logic [7:0]  w_rx_byte;
  logic        w_byte_end;
  logic [7:0]  w_rd_byte;

  assign w_rx_byte  = {r_rx, w_mosi};
  assign w_byte_end = w_sclk_rise && (r_bit_cnt == 3'd7);

  always_comb begin
    w_rd_byte = 8'h00;
    case (r_addr)
      ADDR_WHO_AM_I:  w_rd_byte = WHO_AM_I_VAL;
      ADDR_TEMP_CFG:  w_rd_byte = r_temp_cfg;
      ADDR_CTRL_REG1: w_rd_byte = r_ctrl_reg1;
      ADDR_CTRL_REG4: w_rd_byte = r_ctrl_reg4;
      ADDR_OUT_X_L:   w_rd_byte = r_shadow[7:0];
      ADDR_OUT_X_H:   w_rd_byte = r_shadow[15:8];
      ADDR_OUT_Y_L:   w_rd_byte = r_shadow[23:16];
      ADDR_OUT_Y_H:   w_rd_byte = r_shadow[31:24];
      ADDR_OUT_Z_L:   w_rd_byte = r_shadow[39:32];
      ADDR_OUT_Z_H:   w_rd_byte = r_shadow[47:40];
      default:        w_rd_byte = 8'h00;
    endcase
  end

  // cs_n rise has priority over everything, including a coincident sclk rise.
  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_rise) begin
      w_state_nxt = ST_IDLE;
    end else if (w_cs_fall) begin
      w_state_nxt = ST_CMD;
    end else if (r_state == ST_CMD && w_byte_end) begin
      w_state_nxt = ST_DATA;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 3'd0;
      r_byte_cnt  <= 8'd0;
      r_rx        <= 7'd0;
      r_tx        <= 8'd0;
      r_rw        <= 1'b0;
      r_ms        <= 1'b0;
      r_load_pend <= 1'b0;
      r_addr      <= 6'd0;
      r_shadow    <= 48'd0;
      r_ctrl_reg1 <= CTRL_REG1_RST;
      r_temp_cfg  <= TEMP_CFG_RST;
      r_ctrl_reg4 <= CTRL_REG4_RST;
      r_miso      <= 1'b1;
      r_miso_oe   <= 1'b0;
      r_xfer_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_xfer_done <= 1'b0;
      if (w_cs_rise) begin
        // Partial byte is simply dropped: bit_cnt clears, nothing is written.
        r_xfer_done <= (r_state != ST_IDLE) && (r_byte_cnt != 8'd0);
        r_bit_cnt   <= 3'd0;
        r_load_pend <= 1'b0;
        r_miso      <= 1'b1;
        r_miso_oe   <= 1'b0;
      end else if (w_cs_fall) begin
        // Snapshot keeps the L/H bytes of one burst from different samples.
        r_shadow    <= {acc_z, acc_y, acc_x};
        r_bit_cnt   <= 3'd0;
        r_byte_cnt  <= 8'd0;
        r_load_pend <= 1'b0;
        r_miso      <= 1'b1;
        r_miso_oe   <= 1'b0;
      end else if (r_state != ST_IDLE) begin
        if (w_sclk_rise) begin
          r_rx      <= w_rx_byte[6:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            if (r_byte_cnt != 8'hFF) r_byte_cnt <= r_byte_cnt + 8'd1;
            if (r_state == ST_CMD) begin
              r_rw        <= w_rx_byte[CMD_RW_BIT];
              r_ms        <= w_rx_byte[CMD_MS_BIT];
              r_addr      <= w_rx_byte[5:0];
              r_miso_oe   <= w_rx_byte[CMD_RW_BIT];
              r_load_pend <= w_rx_byte[CMD_RW_BIT];
            end else begin
              if (!r_rw) begin
                case (r_addr)
                  ADDR_CTRL_REG1: r_ctrl_reg1 <= w_rx_byte;
                  ADDR_TEMP_CFG:  r_temp_cfg  <= w_rx_byte;
                  ADDR_CTRL_REG4: r_ctrl_reg4 <= w_rx_byte;
                  default:        ;
                endcase
              end
              if (r_ms) r_addr <= r_addr + 6'd1;
              r_load_pend <= r_rw;
            end
          end
        end else if (w_sclk_fall && r_state == ST_DATA && r_rw) begin
          // First fall of each data byte loads the register; later falls shift.
          if (r_load_pend) begin
            r_miso      <= w_rd_byte[7];
            r_tx        <= {w_rd_byte[6:0], 1'b0};
            r_load_pend <= 1'b0;
          end else begin
            r_miso <= r_tx[7];
            r_tx   <= {r_tx[6:0], 1'b0};
          end
        end
      end
    end
  end

  assign miso      = r_miso;
  assign miso_oe   = r_miso_oe;
  assign ctrl_reg1 = r_ctrl_reg1;
  assign temp_cfg  = r_temp_cfg;
  assign ctrl_reg4 = r_ctrl_reg4;
  assign xfer_done = r_xfer_done;

endmodule

// File: tb/tb_accel_spi_responder.sv
// Directed bench for accel_spi_responder acting as a mode-3 SPI initiator.
// Latency: SCLK half period is 8 clk_in cycles.
// Backpressure: n/a.
module tb_accel_spi_responder;

  logic        clk_in = 1'b0;
  logic        rst    = 1'b1;
  logic        sclk   = 1'b1;
  logic        cs_n   = 1'b1;
  logic        mosi   = 1'b1;
  logic        miso, miso_oe, xfer_done;
  logic [15:0] acc_x = 16'h9A40;
  logic [15:0] acc_y = 16'h1122;
  logic [15:0] acc_z = 16'h3344;
  logic [7:0]  ctrl_reg1, temp_cfg, ctrl_reg4;

  int n_vec      = 0;
  int n_miss     = 0;
  int done_total = 0;
  int d0;

  logic [7:0]  tx_q   [8];
  logic [7:0]  rx_q   [8];
  logic        oe_or  [8];
  logic        oe_and [8];
  int          chg_byte = -1;
  logic [15:0] chg_val  = 16'h0000;
  int          rst_bit  = -1;

  accel_spi_responder #(.WHO_AM_I_VAL(8'h33), .SYNC_STAGES(2)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .acc_x     (acc_x),
    .acc_y     (acc_y),
    .acc_z     (acc_z),
    .ctrl_reg1 (ctrl_reg1),
    .temp_cfg  (temp_cfg),
    .ctrl_reg4 (ctrl_reg4),
    .xfer_done (xfer_done)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (xfer_done) done_total = done_total + 1;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic set_tx(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
    tx_q[0] = b0; tx_q[1] = b1; tx_q[2] = b2; tx_q[3] = b3;
  endtask

  // nfull complete bytes from tx_q, then extra_bits bits of the next byte, then cs_n high.
  task automatic spi_xfer(input int nfull, input int extra_bits);
    int gbit;
    int nb;
    int nbytes;
    gbit   = 0;
    nbytes = nfull + ((extra_bits > 0) ? 1 : 0);
    cs_n = 1'b0;
    wait_clk(8);
    for (int b = 0; b < nbytes; b++) begin
      nb = (b < nfull) ? 8 : extra_bits;
      if (b == chg_byte) acc_x = chg_val;
      rx_q[b]   = 8'h00;
      oe_or[b]  = 1'b0;
      oe_and[b] = 1'b1;
      for (int i = 0; i < nb; i++) begin
        sclk = 1'b0;
        mosi = tx_q[b][7-i];
        wait_clk(8);
        sclk = 1'b1;
        rx_q[b]   = {rx_q[b][6:0], miso};
        oe_or[b]  = oe_or[b] | miso_oe;
        oe_and[b] = oe_and[b] & miso_oe;
        if (gbit == rst_bit) begin
          rst = 1'b1;
          wait_clk(2);
          rst = 1'b0;
          wait_clk(6);
        end else begin
          wait_clk(8);
        end
        gbit = gbit + 1;
      end
    end
    wait_clk(4);
    cs_n = 1'b1;
    mosi = 1'b1;
    wait_clk(12);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      tx_q[k] = 8'h00; rx_q[k] = 8'h00; oe_or[k] = 1'b0; oe_and[k] = 1'b0;
    end
    wait_clk(6);
    chk("rst_miso",      {15'd0, miso},      16'h0001);
    chk("rst_miso_oe",   {15'd0, miso_oe},   16'h0000);
    chk("rst_ctrl_reg1", {8'd0, ctrl_reg1},  16'h0007);
    chk("rst_temp_cfg",  {8'd0, temp_cfg},   16'h0000);
    chk("rst_ctrl_reg4", {8'd0, ctrl_reg4},  16'h0000);
    chk("rst_xfer_done", {15'd0, xfer_done}, 16'h0000);
    rst = 1'b0;
    wait_clk(4);

    // WHO_AM_I read
    set_tx(8'h8F, 8'h00, 8'h00, 8'h00);
    d0 = done_total;
    spi_xfer(2, 0);
    chk("who_am_i",     {8'd0, rx_q[1]},    16'h0033);
    chk("who_oe_cmd",   {15'd0, oe_or[0]},  16'h0000);
    chk("who_oe_data",  {15'd0, oe_and[1]}, 16'h0001);
    chk("who_done",     16'(done_total - d0), 16'h0001);
    chk("who_oe_idle",  {15'd0, miso_oe},   16'h0000);

    // Register writes
    set_tx(8'h20, 8'h77, 8'h00, 8'h00);
    d0 = done_total;
    spi_xfer(2, 0);
    chk("wr_ctrl_reg1", {8'd0, ctrl_reg1}, 16'h0077);
    chk("wr_oe",        {15'd0, oe_or[0] | oe_or[1]}, 16'h0000);
    chk("wr1_done",     16'(done_total - d0), 16'h0001);
    set_tx(8'h1F, 8'hC0, 8'h00, 8'h00);
    d0 = done_total;
    spi_xfer(2, 0);
    chk("wr_temp_cfg",  {8'd0, temp_cfg},  16'h00C0);
    chk("wr2_done",     16'(done_total - d0), 16'h0001);
    set_tx(8'h23, 8'h88, 8'h00, 8'h00);
    spi_xfer(2, 0);
    chk("wr_ctrl_reg4", {8'd0, ctrl_reg4}, 16'h0088);
    chk("wr_keep_reg1", {8'd0, ctrl_reg1}, 16'h0077);

    // Read back a R/W register, then writes to read-only addresses are ignored
    set_tx(8'hA0, 8'h00, 8'h00, 8'h00);
    spi_xfer(2, 0);
    chk("rd_ctrl_reg1", {8'd0, rx_q[1]}, 16'h0077);
    set_tx(8'h0F, 8'h12, 8'h00, 8'h00);
    spi_xfer(2, 0);
    set_tx(8'h28, 8'h55, 8'h00, 8'h00);
    spi_xfer(2, 0);
    set_tx(8'h8F, 8'h00, 8'h00, 8'h00);
    spi_xfer(2, 0);
    chk("ro_who_am_i",  {8'd0, rx_q[1]}, 16'h0033);

    // Auto-increment read with acc_x changing mid-burst
    acc_x    = 16'h9A40;
    chg_byte = 2;
    chg_val  = 16'h1234;
    set_tx(8'hE8, 8'h00, 8'h00, 8'h00);
    spi_xfer(3, 0);
    chg_byte = -1;
    chk("ai_x_l", {8'd0, rx_q[1]}, 16'h0040);
    chk("ai_x_h", {8'd0, rx_q[2]}, 16'h009A);

    // Auto-increment across Y/Z
    set_tx(8'hEB, 8'h00, 8'h00, 8'h00);
    spi_xfer(4, 0);
    chk("ai_y_h", {8'd0, rx_q[1]}, 16'h0011);
    chk("ai_z_l", {8'd0, rx_q[2]}, 16'h0044);
    chk("ai_z_h", {8'd0, rx_q[3]}, 16'h0033);

    // MS=0 read repeats the same address
    acc_x = 16'h9A40;
    set_tx(8'hA8, 8'h00, 8'h00, 8'h00);
    spi_xfer(4, 0);
    chk("ms0_b1", {8'd0, rx_q[1]}, 16'h0040);
    chk("ms0_b2", {8'd0, rx_q[2]}, 16'h0040);
    chk("ms0_b3", {8'd0, rx_q[3]}, 16'h0040);

    // Address wrap 3F -> 00; both unmapped
    set_tx(8'hFF, 8'h00, 8'h00, 8'h00);
    spi_xfer(3, 0);
    chk("wrap_3f", {8'd0, rx_q[1]}, 16'h0000);
    chk("wrap_00", {8'd0, rx_q[2]}, 16'h0000);

    // Abort mid data byte: no write, xfer_done still pulses
    set_tx(8'h20, 8'h55, 8'h00, 8'h00);
    d0 = done_total;
    spi_xfer(1, 4);
    chk("abort_reg1", {8'd0, ctrl_reg1}, 16'h0077);
    chk("abort_done", 16'(done_total - d0), 16'h0001);

    // Abort after the command byte only
    set_tx(8'h20, 8'h00, 8'h00, 8'h00);
    d0 = done_total;
    spi_xfer(1, 0);
    chk("cmdonly_done", 16'(done_total - d0), 16'h0001);
    chk("cmdonly_reg1", {8'd0, ctrl_reg1}, 16'h0077);

    // Abort inside the command byte: no complete byte, no pulse
    set_tx(8'h20, 8'h00, 8'h00, 8'h00);
    d0 = done_total;
    spi_xfer(0, 3);
    chk("partial_done", 16'(done_total - d0), 16'h0000);

    // Reset pulse in the middle of a read
    set_tx(8'h8F, 8'h00, 8'h00, 8'h00);
    rst_bit = 11;
    d0 = done_total;
    spi_xfer(2, 0);
    rst_bit = -1;
    chk("rstmid_reg1", {8'd0, ctrl_reg1}, 16'h0007);
    chk("rstmid_reg4", {8'd0, ctrl_reg4}, 16'h0000);
    chk("rstmid_done", 16'(done_total - d0), 16'h0000);
    chk("rstmid_oe",   {15'd0, miso_oe},  16'h0000);
    d0 = done_total;
    spi_xfer(2, 0);
    chk("post_rst_who",  {8'd0, rx_q[1]}, 16'h0033);
    chk("post_rst_done", 16'(done_total - d0), 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
